// File: rtl/mul_pipe_unit.sv
`default_nettype none
// ============================================================================
// Module      : mul_pipe_unit
// Description : Pipelined RV32M multiply unit (MUL, MULH, MULHSU, MULHU) for
//               the EXE stage. Fixed latency of STAGES cycles, one op per
//               cycle, with stall, flush and a RAW hazard query for decode.
// Ports       : clk_i, rst_i (async, active-high)
//               valid_i/op_i/rs1_i/rs2_i/rd_i  - issue request
//               stall_i  - freeze every stage
//               flush_i  - kill in-flight ops and the same-cycle issue
//               chk_rs1_i/chk_rs2_i - hazard query sources
//               valid_o/result_o/rd_o - retiring op
//               busy_o   - any stage holds a valid op
//               hazard_o - an in-flight rd matches a queried source
// Revision    : 1.0 - initial release
// ============================================================================
module mul_pipe_unit #(
  parameter int XLEN   = 32,
  parameter int STAGES = 4,
  parameter int TAG_W  = 5
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             valid_i,
  input  logic [1:0]       op_i,
  input  logic [XLEN-1:0]  rs1_i,
  input  logic [XLEN-1:0]  rs2_i,
  input  logic [TAG_W-1:0] rd_i,
  input  logic             stall_i,
  input  logic             flush_i,
  input  logic [TAG_W-1:0] chk_rs1_i,
  input  logic [TAG_W-1:0] chk_rs2_i,
  output logic             valid_o,
  output logic [XLEN-1:0]  result_o,
  output logic [TAG_W-1:0] rd_o,
  output logic             busy_o,
  output logic             hazard_o
);

  localparam logic [1:0] c_OP_MUL    = 2'd0;
  localparam logic [1:0] c_OP_MULH   = 2'd1;
  localparam logic [1:0] c_OP_MULHSU = 2'd2;

  // --------------------------------------------------------------------------
  // Product. Operands are extended to 2*XLEN bits according to the op's
  // signedness; a 2*XLEN x 2*XLEN multiply truncated to 2*XLEN bits is exact
  // modulo 2^(2*XLEN), so one unsigned multiplier serves all four modes.
  // --------------------------------------------------------------------------
  logic              w_a_sign;
  logic              w_b_sign;
  logic [2*XLEN-1:0] w_a;
  logic [2*XLEN-1:0] w_b;
  logic [2*XLEN-1:0] w_prod;
  logic [XLEN-1:0]   w_result;

  assign w_a_sign = ((op_i == c_OP_MULH) || (op_i == c_OP_MULHSU)) ? rs1_i[XLEN-1] : 1'b0;
  assign w_b_sign = (op_i == c_OP_MULH) ? rs2_i[XLEN-1] : 1'b0;
  assign w_a      = {{XLEN{w_a_sign}}, rs1_i};
  assign w_b      = {{XLEN{w_b_sign}}, rs2_i};
  assign w_prod   = w_a * w_b;
  assign w_result = (op_i == c_OP_MUL) ? w_prod[XLEN-1:0] : w_prod[2*XLEN-1:XLEN];

  // --------------------------------------------------------------------------
  // Stage registers. Stage 0 captures the issued op; the last stage drives
  // the outputs. Flush outranks stall so a frozen pipe can still be killed.
  // --------------------------------------------------------------------------
  logic [STAGES-1:0] r_valid;
  logic [XLEN-1:0]   r_result [STAGES];
  logic [TAG_W-1:0]  r_rd     [STAGES];

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_valid <= '0;
      for (int k = 0; k < STAGES; k++) begin
        r_result[k] <= '0;
        r_rd[k]     <= '0;
      end
    end else if (flush_i) begin
      r_valid <= '0;
    end else if (!stall_i) begin
      r_valid[0]  <= valid_i;
      r_result[0] <= w_result;
      r_rd[0]     <= rd_i;
      for (int k = 1; k < STAGES; k++) begin
        r_valid[k]  <= r_valid[k-1];
        r_result[k] <= r_result[k-1];
        r_rd[k]     <= r_rd[k-1];
      end
    end
  end

  assign valid_o  = r_valid[STAGES-1];
  assign result_o = r_result[STAGES-1];
  assign rd_o     = r_rd[STAGES-1];
  assign busy_o   = |r_valid;

  // --------------------------------------------------------------------------
  // RAW query against registered stages only; x0 is never a real dependency.
  // --------------------------------------------------------------------------
  logic w_hazard;

  always_comb begin
    w_hazard = 1'b0;
    for (int k = 0; k < STAGES; k++) begin
      if (r_valid[k] && (r_rd[k] != '0) &&
          ((r_rd[k] == chk_rs1_i) || (r_rd[k] == chk_rs2_i))) begin
        w_hazard = 1'b1;
      end
    end
  end

  assign hazard_o = w_hazard;

endmodule
`default_nettype wire

// File: tb/tb_mul_pipe_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_mul_pipe_unit
// Description : Self-checking bench for mul_pipe_unit. Issued ops push their
//               expected result, rd and due cycle to a scoreboard that a
//               negedge monitor pops whenever the unit retires an op.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mul_pipe_unit;

  localparam int XLEN   = 32;
  localparam int STAGES = 4;
  localparam int TAG_W  = 5;

  logic             clk_i = 1'b0;
  logic             rst_i;
  logic             valid_i;
  logic [1:0]       op_i;
  logic [XLEN-1:0]  rs1_i;
  logic [XLEN-1:0]  rs2_i;
  logic [TAG_W-1:0] rd_i;
  logic             stall_i;
  logic             flush_i;
  logic [TAG_W-1:0] chk_rs1_i;
  logic [TAG_W-1:0] chk_rs2_i;
  logic             valid_o;
  logic [XLEN-1:0]  result_o;
  logic [TAG_W-1:0] rd_o;
  logic             busy_o;
  logic             hazard_o;

  mul_pipe_unit #(.XLEN(XLEN), .STAGES(STAGES), .TAG_W(TAG_W)) dut (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .valid_i   (valid_i),
    .op_i      (op_i),
    .rs1_i     (rs1_i),
    .rs2_i     (rs2_i),
    .rd_i      (rd_i),
    .stall_i   (stall_i),
    .flush_i   (flush_i),
    .chk_rs1_i (chk_rs1_i),
    .chk_rs2_i (chk_rs2_i),
    .valid_o   (valid_o),
    .result_o  (result_o),
    .rd_o      (rd_o),
    .busy_o    (busy_o),
    .hazard_o  (hazard_o)
  );

  always #5 clk_i = ~clk_i;

  int cyc = 0;
  always @(posedge clk_i) cyc <= cyc + 1;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, req, cyc);
  endtask

  typedef struct {
    logic [31:0]      res;
    logic [TAG_W-1:0] rd;
    int               due;
  } exp_t;

  exp_t sb[$];

  // Retire monitor: an op is consumed only when stall is low.
  always @(negedge clk_i) begin
    if (!rst_i && valid_o && !stall_i) begin
      if (sb.size() == 0) begin
        check("spurious_valid_o", {31'b0, valid_o}, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("latency",  cyc, e.due);
        check("result_o", result_o, e.res);
        check("rd_o",     {27'b0, rd_o}, {27'b0, e.rd});
      end
    end
  end

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[10];

  // All tasks are entered and left at posedge + 1.
  task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [TAG_W-1:0] rd, input logic [31:0] exp,
                       input int extra, input bit push);
    valid_i = 1'b1;
    op_i    = op;
    rs1_i   = a;
    rs2_i   = b;
    rd_i    = rd;
    if (push) sb.push_back('{exp, rd, cyc + STAGES + extra});
    @(posedge clk_i); #1;
  endtask

  task automatic step();
    @(posedge clk_i); #1;
  endtask

  task automatic drain();
    for (int i = 0; i < 30 && sb.size() != 0; i++) step();
    check("drain", sb.size(), 32'd0);
    step();
  endtask

  task automatic hazard_run(input logic [TAG_W-1:0] rd);
    int c;
    chk_rs1_i = rd;
    chk_rs2_i = 5'd7;
    c = cyc;
    valid_i = 1'b1; op_i = 2'd0; rs1_i = 32'(rd); rs2_i = 32'd2; rd_i = rd;
    sb.push_back('{32'(rd) * 32'd2, rd, c + STAGES});
    @(negedge clk_i);
    check($sformatf("hazard_rd%0d_t0", rd), {31'b0, hazard_o}, 32'd0);
    for (int k = 1; k <= 6; k++) begin
      step();
      valid_i = 1'b0;
      @(negedge clk_i);
      check($sformatf("hazard_rd%0d_t%0d", rd, k), {31'b0, hazard_o},
            {31'b0, (rd != 0) && (k <= 4)});
    end
    step();
    chk_rs1_i = '0;
    chk_rs2_i = '0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got cycle %0d expected < 20000", cyc);
    $fatal(1);
  end

  initial begin
    vecs[0] = '{2'd0, 32'hFFFFFFFF, 32'h00000002, 32'hFFFFFFFE};
    vecs[1] = '{2'd3, 32'hFFFFFFFF, 32'h00000002, 32'h00000001};
    vecs[2] = '{2'd1, 32'hFFFFFFFF, 32'h00000002, 32'hFFFFFFFF};
    vecs[3] = '{2'd2, 32'hFFFFFFFF, 32'h00000002, 32'hFFFFFFFF};
    vecs[4] = '{2'd1, 32'h80000000, 32'h80000000, 32'h40000000};
    vecs[5] = '{2'd0, 32'h80000000, 32'h80000000, 32'h00000000};
    vecs[6] = '{2'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000};
    vecs[7] = '{2'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE};
    vecs[8] = '{2'd1, 32'h7FFFFFFF, 32'h7FFFFFFF, 32'h3FFFFFFF};
    vecs[9] = '{2'd2, 32'h80000000, 32'hFFFFFFFF, 32'h80000000};

    rst_i = 1'b1; valid_i = 1'b0; op_i = '0; rs1_i = '0; rs2_i = '0; rd_i = '0;
    stall_i = 1'b0; flush_i = 1'b0; chk_rs1_i = '0; chk_rs2_i = '0;
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    check("reset_valid_o",  {31'b0, valid_o}, 32'd0);
    check("reset_result_o", result_o, 32'd0);
    check("reset_rd_o",     {27'b0, rd_o}, 32'd0);
    check("reset_busy_o",   {31'b0, busy_o}, 32'd0);
    check("reset_hazard_o", {31'b0, hazard_o}, 32'd0);
    @(posedge clk_i); #1;
    rst_i = 1'b0;
    step();

    // Arithmetic table, issued back to back.
    for (int i = 0; i < 10; i++)
      issue(vecs[i].op, vecs[i].a, vecs[i].b, 5'(i + 1), vecs[i].exp, 0, 1'b1);
    valid_i = 1'b0;
    drain();

    // Four consecutive issues must retire on four consecutive cycles in order.
    for (int i = 1; i <= 4; i++)
      issue(2'd0, 32'(i), 32'd3, 5'(i), 32'(i * 3), 0, 1'b1);
    valid_i = 1'b0;
    drain();

    // Stall mid-pipe for 3 cycles; a request during the stall is refused.
    issue(2'd3, 32'hFFFFFFFF, 32'h00000010, 5'd6, 32'h0000000F, 3, 1'b1);
    valid_i = 1'b0;
    step();
    stall_i = 1'b1; valid_i = 1'b1; rd_i = 5'd9; rs1_i = 32'd1; rs2_i = 32'd1;
    repeat (3) step();
    stall_i = 1'b0; valid_i = 1'b0;
    drain();

    // Stall while the op sits at the output: it is presented unchanged.
    issue(2'd0, 32'd1000, 32'd1000, 5'd11, 32'd1000000, 2, 1'b1);
    valid_i = 1'b0;
    repeat (3) step();
    stall_i = 1'b1;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk_i);
      check("stall_hold_valid",  {31'b0, valid_o}, 32'd1);
      check("stall_hold_result", result_o, 32'd1000000);
      step();
    end
    stall_i = 1'b0;
    drain();

    // Flush with three ops in flight and a same-cycle issue.
    for (int i = 0; i < 3; i++)
      issue(2'd0, 32'd5, 32'd5, 5'(20 + i), 32'd25, 0, 1'b0);
    flush_i = 1'b1;
    rd_i = 5'd23;
    step();
    flush_i = 1'b0; valid_i = 1'b0;
    @(negedge clk_i);
    check("flush_busy_o", {31'b0, busy_o}, 32'd0);
    for (int k = 0; k < 6; k++) begin
      step();
      @(negedge clk_i);
      check("flush_no_valid", {31'b0, valid_o}, 32'd0);
    end
    step();

    // Hazard window, then the x0 case that must never flag.
    hazard_run(5'd5);
    drain();
    hazard_run(5'd0);
    drain();

    // Asynchronous reset with one op retiring and one still in flight.
    issue(2'd0, 32'd7, 32'd6, 5'd12, 32'd42, 0, 1'b1);
    issue(2'd0, 32'd8, 32'd6, 5'd13, 32'd48, 0, 1'b1);
    valid_i = 1'b0;
    repeat (2) step();
    @(negedge clk_i);
    #1;
    rst_i = 1'b1;
    #1;
    check("async_rst_valid_o", {31'b0, valid_o}, 32'd0);
    check("async_rst_busy_o",  {31'b0, busy_o}, 32'd0);
    sb.delete();
    repeat (2) step();
    rst_i = 1'b0;
    for (int k = 0; k < 8; k++) begin
      step();
      @(negedge clk_i);
      check("post_rst_no_valid", {31'b0, valid_o}, 32'd0);
    end
    step();

    check("scoreboard_empty", sb.size(), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
